counter_bus_ctrl: RTL and testbench



---
 rtl/counter_bus_pkg.sv | 18 +
 rtl/counter_bus_ctrl_rr_arbiter.sv | 31 +++
 rtl/counter_bus_ctrl.sv | 131 +++++++++++++
 tb/tb_counter_bus_ctrl.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/counter_bus_pkg.sv
// Shared types and constants for the round-robin counter bus controller.
package counter_bus_pkg;

  localparam int BUS_W = 8;

  typedef enum logic {
    OP_READ = 1'b0,
    OP_LOAD = 1'b1
  } op_e;

  typedef enum logic [1:0] {
    IDLE,
    RD,
    LD,
    TURN
  } state_e;

endpackage

// File: rtl/counter_bus_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter; the last-grant pointer lives in the caller.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int PW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PW-1:0]      last_grant,
  output logic [NUM_REQ-1:0] grant,
  output logic [PW-1:0]      grant_idx,
  output logic               any_grant
);

  logic [PW-1:0] cand;

  // Scan starts just past the previous winner and wraps once around.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    cand      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = PW'((int'(last_grant) + k) % NUM_REQ);
      if (!any_grant && req[cand]) begin
        any_grant   = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/counter_bus_ctrl.sv
// Shares one counter bus between several requesters, one read/load at a time,
// with a turnaround cycle after every operation.
module counter_bus_ctrl
  import counter_bus_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int NUM_CNT = 4,
  parameter int IDXW    = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ-1:0]       req_op,
  input  logic [NUM_REQ*IDXW-1:0]  req_sel,
  input  logic [NUM_REQ*BUS_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]       rsp_valid,
  output logic [BUS_W-1:0]         rsp_data,
  output logic                     rsp_err,
  output logic [NUM_CNT-1:0]       cnt_en,
  output logic [NUM_CNT-1:0]       cnt_load,
  output logic [BUS_W-1:0]         cnt_load_in,
  input  logic [BUS_W-1:0]         bus_in
);

  localparam int PW = $clog2(NUM_REQ);

  state_e             state, next_state;
  logic [PW-1:0]      last_grant, gnt_idx, lat_idx;
  logic [NUM_REQ-1:0] gnt;
  logic               any_gnt, accept, sel_ok;
  logic [IDXW-1:0]    sel_g;
  logic [BUS_W-1:0]   wdata_g;
  op_e                op_g;
  logic [NUM_CNT-1:0] sel_dec;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PW      (PW)
  ) u_arb (
    .req        (req_valid),
    .last_grant (last_grant),
    .grant      (gnt),
    .grant_idx  (gnt_idx),
    .any_grant  (any_gnt)
  );

  // Payload of the current arbitration winner; ready is withheld during reset.
  always_comb begin
    sel_g     = req_sel[int'(gnt_idx)*IDXW +: IDXW];
    wdata_g   = req_wdata[int'(gnt_idx)*BUS_W +: BUS_W];
    op_g      = op_e'(req_op[gnt_idx]);
    sel_ok    = int'(sel_g) < NUM_CNT;
    sel_dec   = NUM_CNT'(1) << sel_g;
    accept    = (state == IDLE) && any_gnt && !rst;
    req_ready = accept ? gnt : '0;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (!sel_ok)               next_state = TURN;
          else if (op_g == OP_LOAD)  next_state = LD;
          else                       next_state = RD;
        end
      end
      RD, LD:  next_state = TURN;
      TURN:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= PW'(NUM_REQ - 1);
      lat_idx    <= '0;
    end else if (accept) begin
      last_grant <= gnt_idx;
      lat_idx    <= gnt_idx;
    end
  end

  // Strobes and responses are registered for the state being entered, so each
  // output is high exactly while the FSM sits in the matching state.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_en      <= '0;
      cnt_load    <= '0;
      cnt_load_in <= '0;
      rsp_valid   <= '0;
      rsp_err     <= 1'b0;
      rsp_data    <= '0;
    end else begin
      cnt_en      <= '0;
      cnt_load    <= '0;
      cnt_load_in <= '0;
      rsp_valid   <= '0;
      rsp_err     <= 1'b0;
      rsp_data    <= '0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (!sel_ok) begin
              rsp_valid <= gnt;
              rsp_err   <= 1'b1;
            end else if (op_g == OP_LOAD) begin
              cnt_load    <= sel_dec;
              cnt_load_in <= wdata_g;
            end else begin
              cnt_en <= sel_dec;
            end
          end
        end
        RD: begin
          rsp_valid <= NUM_REQ'(1) << lat_idx;
          rsp_data  <= bus_in;
        end
        LD: rsp_valid <= NUM_REQ'(1) << lat_idx;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_counter_bus_ctrl.sv
// Directed bench for counter_bus_ctrl with a response scoreboard and bus checks.
module tb_counter_bus_ctrl;

  localparam int NR = 4;
  localparam int NC = 4;
  localparam int IW = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic [NR-1:0]   req_valid, req_ready, req_op, rsp_valid;
  logic [NR*IW-1:0] req_sel;
  logic [NR*8-1:0] req_wdata;
  logic [7:0]      rsp_data, cnt_load_in, bus_in;
  logic            rsp_err;
  logic [NC-1:0]   cnt_en, cnt_load;

  typedef struct {
    int         idx;
    logic [7:0] data;
    logic       err;
  } rsp_t;

  rsp_t       sb[$];
  rsp_t       e;
  int         total = 0;
  int         bad = 0;
  int         g;
  logic [7:0] cnt [NC];
  logic [NC-1:0] prev_en = '0;

  counter_bus_ctrl #(.NUM_REQ(NR), .NUM_CNT(NC), .IDXW(IW)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_sel     (req_sel),
    .req_wdata   (req_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_data    (rsp_data),
    .rsp_err     (rsp_err),
    .cnt_en      (cnt_en),
    .cnt_load    (cnt_load),
    .cnt_load_in (cnt_load_in),
    .bus_in      (bus_in)
  );

  always #5 clk = ~clk;

  // Counters reset to 0x10<<i, count every clock, and load on their strobe.
  always @(posedge clk) begin
    for (int i = 0; i < NC; i++) begin
      if (rst)              cnt[i] <= 8'(8'h10 << i);
      else if (cnt_load[i]) cnt[i] <= cnt_load_in;
      else                  cnt[i] <= cnt[i] + 8'd1;
    end
  end

  always_comb begin
    bus_in = 8'h00;
    for (int i = 0; i < NC; i++)
      if (cnt_en[i]) bus_in = cnt[i];
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input int i, input logic op, input int sel,
                               input logic [7:0] wdata, input logic valid);
    req_valid[i]           = valid;
    req_op[i]              = op;
    req_sel[i*IW +: IW]    = IW'(sel);
    req_wdata[i*8 +: 8]    = wdata;
  endtask

  always @(negedge clk) begin
    if (rsp_valid !== '0) begin
      if (sb.size() == 0) begin
        checkOutput("rsp_unexpected", 32'(rsp_valid), 32'd0);
      end else begin
        e = sb.pop_front();
        checkOutput("rsp_valid", 32'(rsp_valid), 32'(1) << e.idx);
        checkOutput("rsp_data", 32'(rsp_data), 32'(e.data));
        checkOutput("rsp_err", 32'(rsp_err), 32'(e.err));
      end
    end
  end

  always @(negedge clk) begin
    checkOutput("bus_turnaround", 32'((prev_en != '0) && (cnt_en != '0)), 32'd0);
    checkOutput("en_load_excl", 32'((cnt_en != '0) && (cnt_load != '0)), 32'd0);
    checkOutput("ready_onehot0", 32'($onehot0(req_ready)), 32'd1);
    prev_en <= cnt_en;
  end

  initial begin
    rst = 1'b1;
    req_valid = '0; req_op = '0; req_sel = '0; req_wdata = '0;
    applyStimulus(1, 1'b0, 0, 8'h00, 1'b1);
    repeat (2) @(negedge clk);
    #1;
    checkOutput("rst_ready", 32'(req_ready), 32'd0);
    checkOutput("rst_cnt_en", 32'(cnt_en), 32'd0);
    checkOutput("rst_cnt_load", 32'(cnt_load), 32'd0);
    checkOutput("rst_load_in", 32'(cnt_load_in), 32'd0);
    checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("rst_rsp_err", 32'(rsp_err), 32'd0);
    checkOutput("rst_rsp_data", 32'(rsp_data), 32'd0);

    // Single read of counter 2 by requester 0 (cycle 0 = acceptance).
    rst = 1'b0;
    applyStimulus(1, 1'b0, 0, 8'h00, 1'b0);
    applyStimulus(0, 1'b0, 2, 8'h00, 1'b1);
    #1;
    checkOutput("rd_ready", 32'(req_ready), 32'b0001);
    sb.push_back('{idx: 0, data: 8'h41, err: 1'b0});
    @(negedge clk); applyStimulus(0, 1'b0, 2, 8'h00, 1'b0); #1;
    checkOutput("rd_cnt_en", 32'(cnt_en), 32'b0100);
    checkOutput("rd_cnt_load", 32'(cnt_load), 32'd0);
    checkOutput("rd_busy_ready", 32'(req_ready), 32'd0);
    @(negedge clk); #1;
    checkOutput("rd_en_off", 32'(cnt_en), 32'd0);
    checkOutput("rd_rsp_cycle", 32'(rsp_valid), 32'b0001);

    // Load 0xFE into counter 3, then read it back two cycles later (wraps to 0x00).
    @(negedge clk); applyStimulus(1, 1'b1, 3, 8'hFE, 1'b1); #1;
    checkOutput("ld_ready", 32'(req_ready), 32'b0010);
    sb.push_back('{idx: 1, data: 8'h00, err: 1'b0});
    @(negedge clk); applyStimulus(1, 1'b0, 3, 8'h00, 1'b1); #1;
    checkOutput("ld_cnt_load", 32'(cnt_load), 32'b1000);
    checkOutput("ld_load_in", 32'(cnt_load_in), 32'hFE);
    checkOutput("ld_cnt_en", 32'(cnt_en), 32'd0);
    @(negedge clk); #1;
    checkOutput("ld_cnt3_value", 32'(cnt[3]), 32'hFE);
    checkOutput("ld_rsp_cycle", 32'(rsp_valid), 32'b0010);
    @(negedge clk); #1;
    checkOutput("rb_ready", 32'(req_ready), 32'b0010);
    sb.push_back('{idx: 1, data: 8'h00, err: 1'b0});
    @(negedge clk); applyStimulus(1, 1'b0, 3, 8'h00, 1'b0); #1;
    checkOutput("rb_cnt_en", 32'(cnt_en), 32'b1000);
    @(negedge clk); #1;
    checkOutput("rb_rsp_cycle", 32'(rsp_valid), 32'b0010);

    // Invalid select from requester 3: error response one cycle after acceptance.
    @(negedge clk); applyStimulus(3, 1'b0, 5, 8'h00, 1'b1); #1;
    checkOutput("err_ready", 32'(req_ready), 32'b1000);
    sb.push_back('{idx: 3, data: 8'h00, err: 1'b1});
    @(negedge clk); applyStimulus(3, 1'b0, 5, 8'h00, 1'b0); #1;
    checkOutput("err_cnt_en", 32'(cnt_en), 32'd0);
    checkOutput("err_cnt_load", 32'(cnt_load), 32'd0);
    checkOutput("err_rsp_cycle", 32'(rsp_valid), 32'b1000);

    // Round robin with all four requesters loading continuously.
    @(negedge clk);
    for (int i = 0; i < NR; i++) applyStimulus(i, 1'b1, i, 8'(32'hA0 + i), 1'b1);
    #1;
    checkOutput("rr_idle_rsp", 32'(rsp_valid), 32'd0);
    for (int n = 0; n < 5; n++) begin
      g = n % NR;
      if (n > 0) @(negedge clk);
      #1;
      checkOutput("rr_ready", 32'(req_ready), 32'(1) << g);
      sb.push_back('{idx: g, data: 8'h00, err: 1'b0});
      @(negedge clk);
      if (n == 4) req_valid = '0;
      #1;
      checkOutput("rr_cnt_load", 32'(cnt_load), 32'(1) << g);
      checkOutput("rr_load_in", 32'(cnt_load_in), 32'hA0 + 32'(g));
      @(negedge clk); #1;
      checkOutput("rr_turn_ready", 32'(req_ready), 32'd0);
    end

    // Reset during a read: no response, pointer returns to favour requester 0.
    @(negedge clk); applyStimulus(0, 1'b0, 1, 8'h00, 1'b1); #1;
    checkOutput("mr_ready", 32'(req_ready), 32'b0001);
    @(negedge clk);
    rst = 1'b1;
    applyStimulus(2, 1'b0, 2, 8'h00, 1'b1);
    #1;
    checkOutput("mr_cnt_en", 32'(cnt_en), 32'b0010);
    checkOutput("mr_rst_ready", 32'(req_ready), 32'd0);
    @(negedge clk); #1;
    checkOutput("mr_cnt_en_off", 32'(cnt_en), 32'd0);
    checkOutput("mr_cnt_load", 32'(cnt_load), 32'd0);
    checkOutput("mr_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("mr_rsp_data", 32'(rsp_data), 32'd0);
    checkOutput("mr_rsp_err", 32'(rsp_err), 32'd0);
    checkOutput("mr_load_in", 32'(cnt_load_in), 32'd0);
    rst = 1'b0;
    #1;
    checkOutput("mr_after_ready", 32'(req_ready), 32'b0001);
    sb.push_back('{idx: 0, data: 8'h21, err: 1'b0});
    @(negedge clk); applyStimulus(0, 1'b0, 1, 8'h00, 1'b0); #1;
    checkOutput("mr_rd_en", 32'(cnt_en), 32'b0010);
    @(negedge clk); #1;
    checkOutput("mr_rsp_cycle", 32'(rsp_valid), 32'b0001);
    @(negedge clk); #1;
    checkOutput("mr_req2_ready", 32'(req_ready), 32'b0100);
    sb.push_back('{idx: 2, data: 8'h44, err: 1'b0});
    @(negedge clk); applyStimulus(2, 1'b0, 2, 8'h00, 1'b0); #1;
    checkOutput("mr_req2_en", 32'(cnt_en), 32'b0100);
    @(negedge clk); #1;
    checkOutput("mr_req2_rsp", 32'(rsp_valid), 32'b0100);
    @(negedge clk); #1;
    checkOutput("sb_drained", 32'(sb.size()), 32'd0);
    checkOutput("final_rsp_idle", 32'(rsp_valid), 32'd0);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
